// File: rtl/event_input_conditioner.sv
// -----------------------------------------------------------------------------
// event_input_conditioner
//
// Brings 32 raw interrupt/event request lines into the HCLK domain and turns
// each one into either a single-cycle pulse (rising, falling or both edges) or
// a clean level, chosen per line. A small APB register file holds the per-line
// enable and mode. The block sits in front of the event unit's irq_i or
// event_i input; one instance is used for each.
//
// Parameters:
//   APB_ADDR_WIDTH : APB address width (must be greater than 4)
//   SYNC_STAGES    : synchronizer depth per line, 2..4
//
// Ports:
//   HCLK, HRESETn  : clock, asynchronous active-low reset
//   PADDR, PWDATA, PWRITE, PSEL, PENABLE : APB request
//   PRDATA, PREADY, PSLVERR              : APB response
//   req_i[31:0]    : raw requests, asynchronous to HCLK
//   signal_o[31:0] : conditioned lines (registered)
//
// Register map (PADDR[3:2]; any nonzero PADDR[APB_ADDR_WIDTH-1:4] is unmapped):
//   0x00 EN      RW  per-line enable
//   0x04 MODE_LO RW  2 bits per line, lines 0..15
//   0x08 MODE_HI RW  2 bits per line, lines 16..31
//   0x0C STATUS  RO  synchronized level of every line (writes ignored)
// Mode: 00 rising pulse, 01 falling pulse, 10 both edges, 11 level.
//
// APB handshake: PREADY is always 1, so every access completes in its access
// phase (PSEL & PENABLE). A write commits on the HCLK edge where
// PSEL & PENABLE & PWRITE is high; read data is combinational from the current
// register state and is 0 whenever no mapped read is selected. PSLVERR is 1
// only during the access phase of an unmapped access.
// -----------------------------------------------------------------------------
module event_input_conditioner #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [31:0]               req_i,
    output logic [31:0]               signal_o
);

    localparam logic [1:0] MODE_RISE  = 2'b00;
    localparam logic [1:0] MODE_FALL  = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;
    localparam logic [1:0] MODE_LEVEL = 2'b11;

    // Register file
    logic [31:0] en_q;
    logic [31:0] mode_lo_q;
    logic [31:0] mode_hi_q;

    // Per-line conditioning state
    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] prev_q;
    logic [31:0] signal_q;

    logic [31:0] s;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [63:0] mode_all;
    logic [31:0] signal_d;

    // APB decode
    logic        mapped;
    logic        access;
    logic        wr_en;
    logic [1:0]  reg_sel;
    logic [31:0] rd_mux;

    // Byte-offset bits carry no information for word registers.
    logic        unused_paddr;
    assign unused_paddr = ^PADDR[1:0];

    assign mapped  = (PADDR[APB_ADDR_WIDTH-1:4] == '0);
    assign reg_sel = PADDR[3:2];
    assign access  = PSEL & PENABLE;
    assign wr_en   = access & PWRITE & mapped;

    // ---------------------------------------------------------------------
    // Register writes. STATUS is read-only, so offset 0x0C falls through.
    // ---------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en_q      <= '0;
            mode_lo_q <= '0;
            mode_hi_q <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                2'd0:    en_q      <= PWDATA;
                2'd1:    mode_lo_q <= PWDATA;
                2'd2:    mode_hi_q <= PWDATA;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Read path and response.
    // ---------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0:    rd_mux = en_q;
            2'd1:    rd_mux = mode_lo_q;
            2'd2:    rd_mux = mode_hi_q;
            default: rd_mux = s;
        endcase
    end

    assign PRDATA  = (PSEL && !PWRITE && mapped) ? rd_mux : 32'h0;
    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~mapped;

    // ---------------------------------------------------------------------
    // Synchronizer and edge history. prev_q tracks s regardless of EN so that
    // enabling a line that is already high does not look like a rising edge.
    // ---------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q   <= '0;
            signal_q <= '0;
        end else begin
            sync_q[0] <= req_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q   <= s;
            signal_q <= signal_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    // Line n's mode sits at bits [2n+1:2n] of the concatenated mode word,
    // which makes the 15/16 boundary between MODE_LO and MODE_HI seamless.
    assign mode_all = {mode_hi_q, mode_lo_q};

    always_comb begin
        signal_d = '0;
        for (int n = 0; n < 32; n++) begin
            case (mode_all[2*n +: 2])
                MODE_RISE:  signal_d[n] = rise[n];
                MODE_FALL:  signal_d[n] = fall[n];
                MODE_BOTH:  signal_d[n] = rise[n] | fall[n];
                MODE_LEVEL: signal_d[n] = s[n];
                default:    signal_d[n] = 1'b0;
            endcase
        end
        signal_d = signal_d & en_q;
    end

    assign signal_o = signal_q;

endmodule

// File: tb/tb_event_input_conditioner.sv
// -----------------------------------------------------------------------------
// Bench for event_input_conditioner.
//
// A reference model keeps a history of the request word sampled at each HCLK
// edge. The synchronized level after edge t is the request sampled SYNC-1
// edges earlier, so the output after edge t follows from two history entries
// plus the enable/mode words in force before that edge. The model pushes one
// expected output word per edge; a monitor pops and compares on the falling
// edge. APB reads are checked against the model's register copy.
// -----------------------------------------------------------------------------
module tb_event_input_conditioner;

    localparam int AW   = 12;
    localparam int SYNC = 2;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // DUT signals
    logic [AW-1:0] paddr   = '0;
    logic [31:0]   pwdata  = '0;
    logic          pwrite  = 1'b0;
    logic          psel    = 1'b0;
    logic          penable = 1'b0;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic [31:0]   req     = '0;
    logic [31:0]   signal_o;

    event_input_conditioner #(
        .APB_ADDR_WIDTH (AW),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .HCLK     (clk),
        .HRESETn  (rst_n),
        .PADDR    (paddr),
        .PWDATA   (pwdata),
        .PWRITE   (pwrite),
        .PSEL     (psel),
        .PENABLE  (penable),
        .PRDATA   (prdata),
        .PREADY   (pready),
        .PSLVERR  (pslverr),
        .req_i    (req),
        .signal_o (signal_o)
    );

    // ---------------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    logic [31:0] m_en;
    logic [31:0] m_lo;
    logic [31:0] m_hi;
    logic [31:0] m_s;
    logic [31:0] hist[$];   // hist[j] = request sampled j edges ago

    function automatic logic [31:0] line_out(input logic [31:0] cur, input logic [31:0] old,
                                             input logic [31:0] en, input logic [31:0] lo,
                                             input logic [31:0] hi);
        logic [31:0] r;
        logic [1:0]  md;
        r = '0;
        for (int n = 0; n < 32; n++) begin
            md = (n < 16) ? lo[2*n +: 2] : hi[2*(n-16) +: 2];
            case (md)
                2'd0: r[n] = cur[n] && !old[n];
                2'd1: r[n] = !cur[n] && old[n];
                2'd2: r[n] = cur[n] != old[n];
                default: r[n] = cur[n];
            endcase
            r[n] = r[n] && en[n];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_en = '0;
        m_lo = '0;
        m_hi = '0;
        m_s  = '0;
        hist.delete();
        for (int i = 0; i < SYNC + 2; i++) hist.push_back('0);
        exp_q.delete();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                hist.push_front(req);
                void'(hist.pop_back());
                // Output after this edge uses the levels present before it
                // and the register values before any write on this edge.
                exp_q.push_back(line_out(hist[SYNC], hist[SYNC+1], m_en, m_lo, m_hi));
                m_s = hist[SYNC-1];
                if (psel && penable && pwrite && paddr[AW-1:4] == '0) begin
                    case (paddr[3:2])
                        2'd0: m_en = pwdata;
                        2'd1: m_lo = pwdata;
                        2'd2: m_hi = pwdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    function automatic logic [31:0] exp_read(input logic [AW-1:0] a);
        if (a[AW-1:4] != '0) return 32'h0;
        case (a[3:2])
            2'd0:    return m_en;
            2'd1:    return m_lo;
            2'd2:    return m_hi;
            default: return m_s;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Monitor: one expected word per edge
    // ---------------------------------------------------------------------
    logic [31:0] mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("signal_o", signal_o, mon_exp);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input logic [31:0] v);
        @(negedge clk);
        req = v;
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("pslverr_wr", {31'b0, pslverr}, {31'b0, a[AW-1:4] != '0});
        check("pready_wr", {31'b0, pready}, 32'h1);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("prdata", prdata, exp_read(a));
        check("pslverr_rd", {31'b0, pslverr}, {31'b0, a[AW-1:4] != '0});
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [AW-1:0] addr_tab [6];

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        addr_tab[0] = 12'h000; addr_tab[1] = 12'h004; addr_tab[2] = 12'h008;
        addr_tab[3] = 12'h00C; addr_tab[4] = 12'h010; addr_tab[5] = 12'h120;

        // Reset state
        wait_cycles(3);
        #1;
        check("rst_signal", signal_o, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", {31'b0, pready}, 32'h1);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Line 0 rising edge
        apb_write(12'h000, 32'h1);
        apb_write(12'h004, 32'h0);
        set_req(32'h1);
        wait_cycles(6);
        apb_read(12'h00C);

        // Line 0 falling edge, then level
        apb_write(12'h004, 32'h1);
        set_req(32'h0);
        wait_cycles(6);
        set_req(32'h1);
        wait_cycles(6);
        apb_write(12'h004, 32'h3);
        for (int i = 0; i < 4; i++) begin
            set_req(req ^ 32'h1);
            wait_cycles(i + 2);
        end
        set_req(32'h0);
        wait_cycles(4);

        // All lines high before enable, then all falling together
        apb_write(12'h000, 32'h0);
        apb_write(12'h004, 32'h0);
        set_req(32'hFFFF_FFFF);
        wait_cycles(6);
        apb_write(12'h000, 32'hFFFF_FFFF);
        wait_cycles(4);
        apb_write(12'h004, 32'h5555_5555);
        apb_write(12'h008, 32'h5555_5555);
        set_req(32'h0);
        wait_cycles(6);

        // Line 16 both edges, then level with enable cleared mid-level
        apb_write(12'h000, 32'h0001_0000);
        apb_write(12'h008, 32'h2);
        for (int i = 0; i < 4; i++) begin
            set_req(req ^ 32'h0001_0000);
            wait_cycles(3);
        end
        apb_write(12'h008, 32'h3);
        set_req(32'h0001_8000);
        wait_cycles(6);
        apb_write(12'h000, 32'h0);
        wait_cycles(3);

        // Unmapped and read-only accesses, then read-back
        apb_read(12'h010);
        apb_write(12'h00C, 32'hDEAD_BEEF);
        apb_write(12'h010, 32'h1234_5678);
        apb_write(12'h000, 32'hA5A5_0F0F);
        apb_write(12'h004, 32'h1B1B_E4E4);
        apb_write(12'h008, 32'hC3C3_3C3C);
        apb_read(12'h000);
        apb_read(12'h004);
        apb_read(12'h008);
        apb_read(12'h00C);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            set_req(req ^ ($urandom & $urandom & $urandom));
            wait_cycles($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) apb_write(addr_tab[$urandom_range(0, 5)], $urandom);
            if ($urandom_range(0, 4) == 0) apb_read(addr_tab[$urandom_range(0, 5)]);
        end

        // Level mode on every line, then asynchronous reset mid-operation
        apb_write(12'h000, 32'hFFFF_FFFF);
        apb_write(12'h004, 32'hFFFF_FFFF);
        apb_write(12'h008, 32'hFFFF_FFFF);
        set_req(32'hFFFF_FFFF);
        wait_cycles(5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_signal", signal_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apb_read(12'h000);
        wait_cycles(8);
        apb_read(12'h00C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
